// File: rtl/mips16_wb_pkg.sv
// rtl/mips16_wb_pkg.sv - shared types, widths and decode helper for the write-back commit queue
package mips16_wb_pkg;

   localparam int WB_DATA_W = 16;
   localparam int WB_REG_AW = 3;
   localparam int WB_NREGS  = 1 << WB_REG_AW;

   // One queued write-back; ready means data holds the final result.
   typedef struct packed {
      logic [WB_REG_AW-1:0] dest;
      logic [WB_DATA_W-1:0] data;
      logic                 is_load;
      logic                 ready;
   } wb_entry_t;

   function automatic logic [WB_NREGS-1:0] onehot_dest(input logic [WB_REG_AW-1:0] dest);
      logic [WB_NREGS-1:0] vec;
      vec       = '0;
      vec[dest] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/wb_commit_queue_if.sv
// rtl/wb_commit_queue_if.sv - instruction, load-response and register-write bundle of the commit queue
interface wb_commit_queue_if
   import mips16_wb_pkg::*;
#(
   parameter int DATA_W = WB_DATA_W,
   parameter int REG_AW = WB_REG_AW,
   parameter int DEPTH  = 4
);
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic                 in_valid;
   logic                 in_ready;
   logic                 in_wb_en;
   logic [REG_AW-1:0]    in_wb_dest;
   logic                 in_is_load;
   logic [DATA_W-1:0]    in_alu_result;
   logic                 mem_rdata_valid;
   logic [DATA_W-1:0]    mem_rdata;
   logic                 reg_write_en;
   logic [REG_AW-1:0]    reg_write_dest;
   logic [DATA_W-1:0]    reg_write_data;
   logic [2**REG_AW-1:0] pending_mask;
   logic [OCC_W-1:0]     occupancy;
   logic                 proto_err;

   // Pipeline / memory side that feeds the queue.
   modport master (
      output in_valid, in_wb_en, in_wb_dest, in_is_load, in_alu_result,
      output mem_rdata_valid, mem_rdata,
      input  in_ready, reg_write_en, reg_write_dest, reg_write_data,
      input  pending_mask, occupancy, proto_err
   );

   // The commit queue itself.
   modport slave (
      input  in_valid, in_wb_en, in_wb_dest, in_is_load, in_alu_result,
      input  mem_rdata_valid, mem_rdata,
      output in_ready, reg_write_en, reg_write_dest, reg_write_data,
      output pending_mask, occupancy, proto_err
   );

endinterface

// File: rtl/wb_queue_mem.sv
// rtl/wb_queue_mem.sv - entry storage with a tail write port and a load-data fill port
module wb_queue_mem
   import mips16_wb_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [IDX_W-1:0]     wr_idx,
   input  wb_entry_t            wr_entry,
   input  logic                 fill_en,
   input  logic [IDX_W-1:0]     fill_idx,
   input  logic [WB_DATA_W-1:0] fill_data,
   output wb_entry_t            entries [DEPTH]
);

   wb_entry_t entries_q [DEPTH];
   wb_entry_t entries_d [DEPTH];

   // Fill and tail write never target the same slot: the fill target is
   // already occupied while the tail slot is free.
   always_comb begin
      entries_d = entries_q;
      if (fill_en) begin
         entries_d[fill_idx].data  = fill_data;
         entries_d[fill_idx].ready = 1'b1;
      end
      if (wr_en) begin
         entries_d[wr_idx] = wr_entry;
      end
   end

   // Register the storage array; cleared on reset so contents are deterministic.
   always_ff @(posedge clk) begin
      if (rst) begin
         entries_q <= '{default: '0};
      end else begin
         entries_q <= entries_d;
      end
   end

   assign entries = entries_q;

endmodule

// File: rtl/wb_commit_queue.sv
// rtl/wb_commit_queue.sv - in-order write-back commit queue with late load completion
module wb_commit_queue
   import mips16_wb_pkg::*;
#(
   parameter int DATA_W = WB_DATA_W,
   parameter int REG_AW = WB_REG_AW,
   parameter int DEPTH  = 4
) (
   input  logic           clk,
   input  logic           rst,
   wb_commit_queue_if.slave bus
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int NREGS = 1 << REG_AW;
   localparam logic [IDX_W:0] PTR_ONE = 1;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [IDX_W:0]   head_q, head_d;
   logic [IDX_W:0]   tail_q, tail_d;
   logic [DEPTH-1:0] valid_q, valid_d;
   logic             proto_err_q, proto_err_d;

   logic [IDX_W-1:0] head_idx;
   logic [IDX_W-1:0] tail_idx;
   logic [IDX_W:0]   occ;
   logic             full;
   logic             accept;
   logic             push;
   logic             retire;
   logic             fill;
   logic             resp_found;
   logic [IDX_W-1:0] resp_idx;
   logic [IDX_W-1:0] scan_idx;
   logic [NREGS-1:0] mask;
   wb_entry_t        wr_entry;
   wb_entry_t        entries [DEPTH];

   assign head_idx = head_q[IDX_W-1:0];
   assign tail_idx = tail_q[IDX_W-1:0];

   // Queue fill level and full detection from the wrap-bit pointers.
   always_comb begin
      occ  = tail_q - head_q;
      full = (head_q[IDX_W] != tail_q[IDX_W]) && (head_idx == tail_idx);
   end

   // Locate the oldest load still waiting for data; responses complete loads in program order.
   always_comb begin
      resp_found = 1'b0;
      resp_idx   = head_idx;
      scan_idx   = head_idx;
      for (int k = 0; k < DEPTH; k++) begin
         scan_idx = head_idx + k[IDX_W-1:0];
         if (!resp_found && valid_q[scan_idx] &&
             entries[scan_idx].is_load && !entries[scan_idx].ready) begin
            resp_found = 1'b1;
            resp_idx   = scan_idx;
         end
      end
   end

   // Accept, retire and error bookkeeping for the next state.
   always_comb begin
      head_d      = head_q;
      tail_d      = tail_q;
      valid_d     = valid_q;
      accept      = bus.in_valid && !full;
      push        = accept && bus.in_wb_en;
      retire      = valid_q[head_idx] && entries[head_idx].ready;
      fill        = bus.mem_rdata_valid && resp_found;
      proto_err_d = proto_err_q
                  | (bus.mem_rdata_valid && !resp_found)
                  | (accept && bus.in_is_load && !bus.in_wb_en);
      if (retire) begin
         valid_d[head_idx] = 1'b0;
         head_d            = head_q + PTR_ONE;
      end
      if (push) begin
         valid_d[tail_idx] = 1'b1;
         tail_d            = tail_q + PTR_ONE;
      end
   end

   // Build the entry written at the tail; ALU results are final on entry.
   always_comb begin
      wr_entry         = '0;
      wr_entry.dest    = bus.in_wb_dest;
      wr_entry.data    = bus.in_alu_result;
      wr_entry.is_load = bus.in_is_load;
      wr_entry.ready   = !bus.in_is_load;
   end

   // Pending-destination mask over every occupied slot, including the retiring head.
   always_comb begin
      mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i]) begin
            mask = mask | onehot_dest(entries[i].dest);
         end
      end
   end

   // Pointer, valid and sticky error state.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q      <= '0;
         tail_q      <= '0;
         valid_q     <= '0;
         proto_err_q <= 1'b0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         valid_q     <= valid_d;
         proto_err_q <= proto_err_d;
      end
   end

   wb_queue_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (push),
      .wr_idx    (tail_idx),
      .wr_entry  (wr_entry),
      .fill_en   (fill),
      .fill_idx  (resp_idx),
      .fill_data (bus.mem_rdata),
      .entries   (entries)
   );

   assign bus.in_ready       = !full;
   assign bus.reg_write_en   = retire;
   assign bus.reg_write_dest = entries[head_idx].dest;
   assign bus.reg_write_data = entries[head_idx].data;
   assign bus.pending_mask   = mask;
   assign bus.occupancy      = occ;
   assign bus.proto_err      = proto_err_q;

endmodule

// File: tb/tb_wb_commit_queue.sv
// tb/tb_wb_commit_queue.sv - randomized and directed checks of wb_commit_queue against a queue model
module tb_wb_commit_queue;
   import mips16_wb_pkg::*;

   localparam int DATA_W = 16;
   localparam int REG_AW = 3;
   localparam int DEPTH  = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wb_commit_queue_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH)) bus ();

   wb_commit_queue #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic [REG_AW-1:0] dest;
      logic [DATA_W-1:0] data;
      bit                is_load;
      bit                ready;
   } m_entry_t;

   m_entry_t mq[$];
   bit       m_err;
   int       n_checks = 0;
   int       n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic bit model_has_waiting_load();
      foreach (mq[i]) if (mq[i].is_load && !mq[i].ready) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check_outputs();
      logic [2**REG_AW-1:0] exp_mask;
      bit exp_en;
      exp_mask = '0;
      foreach (mq[i]) exp_mask[mq[i].dest] = 1'b1;
      exp_en = (mq.size() > 0) && mq[0].ready;
      check_val("occupancy", bus.occupancy, mq.size());
      check_val("in_ready", bus.in_ready, (mq.size() != DEPTH));
      check_val("pending_mask", bus.pending_mask, exp_mask);
      check_val("proto_err", bus.proto_err, m_err);
      check_val("reg_write_en", bus.reg_write_en, exp_en);
      if (exp_en) begin
         check_val("reg_write_dest", bus.reg_write_dest, mq[0].dest);
         check_val("reg_write_data", bus.reg_write_data, mq[0].data);
      end
   endtask

   task automatic drive_idle();
      bus.in_valid        = 1'b0;
      bus.in_wb_en        = 1'b0;
      bus.in_wb_dest      = '0;
      bus.in_is_load      = 1'b0;
      bus.in_alu_result   = '0;
      bus.mem_rdata_valid = 1'b0;
      bus.mem_rdata       = '0;
   endtask

   // One clock: drive inputs, advance the model by the same rules, check after the edge.
   task automatic step(input bit v, input bit wb, input logic [REG_AW-1:0] dest, input bit ld,
                       input logic [DATA_W-1:0] alu, input bit rv, input logic [DATA_W-1:0] rd);
      bit acc;
      bit ret;
      int fi;
      m_entry_t e;
      bus.in_valid        = v;
      bus.in_wb_en        = wb;
      bus.in_wb_dest      = dest;
      bus.in_is_load      = ld;
      bus.in_alu_result   = alu;
      bus.mem_rdata_valid = rv;
      bus.mem_rdata       = rd;
      acc = v && (mq.size() != DEPTH);
      ret = (mq.size() > 0) && mq[0].ready;
      fi  = -1;
      foreach (mq[i]) if (fi < 0 && mq[i].is_load && !mq[i].ready) fi = i;
      if (rv) begin
         if (fi >= 0) begin
            mq[fi].data  = rd;
            mq[fi].ready = 1'b1;
         end else begin
            m_err = 1'b1;
         end
      end
      if (acc && ld && !wb) m_err = 1'b1;
      if (ret) void'(mq.pop_front());
      if (acc && wb) begin
         e.dest = dest; e.data = alu; e.is_load = ld; e.ready = !ld;
         mq.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      drive_idle();
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      drive_idle();
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      mq.delete();
      m_err = 1'b0;
      check_outputs();
   endtask

   initial begin
      drive_idle();
      m_err = 1'b0;
      do_reset();
      check_val("reset_pending_mask", bus.pending_mask, 0);
      check_val("reset_in_ready", bus.in_ready, 1);

      // ALU-only: r1 then r2 on consecutive cycles
      step(1, 1, 3'd1, 0, 16'h1234, 0, 0);
      check_val("alu_r1_data", bus.reg_write_data, 16'h1234);
      step(1, 1, 3'd2, 0, 16'h00FF, 0, 0);
      check_val("alu_r2_data", bus.reg_write_data, 16'h00FF);
      idle(2);

      // Late load: r3 load, r4 ALU, response four cycles later
      step(1, 1, 3'd3, 1, 16'h0000, 0, 0);
      step(1, 1, 3'd4, 0, 16'h0005, 0, 0);
      idle(2);
      check_val("load_no_early_write", bus.reg_write_en, 0);
      step(0, 0, 0, 0, 0, 1, 16'hBEEF);
      check_val("load_r3_dest", bus.reg_write_dest, 3);
      check_val("load_r3_data", bus.reg_write_data, 16'hBEEF);
      idle(1);
      check_val("load_r4_data", bus.reg_write_data, 16'h0005);
      idle(1);

      // Full: four loads, fifth held, then one response frees a slot
      for (int i = 0; i < 4; i++) step(1, 1, i[REG_AW-1:0], 1, 0, 0, 0);
      check_val("full_occupancy", bus.occupancy, 4);
      step(1, 1, 3'd7, 0, 16'h0077, 0, 0);
      check_val("full_in_ready", bus.in_ready, 0);
      step(1, 1, 3'd7, 0, 16'h0077, 1, 16'hA000);
      step(1, 1, 3'd7, 0, 16'h0077, 0, 0);
      for (int i = 1; i < 4; i++) step(0, 0, 0, 0, 0, 1, 16'hA000 + i[DATA_W-1:0]);
      idle(5);

      // Same destination twice
      step(1, 1, 3'd5, 0, 16'h0001, 0, 0);
      step(1, 1, 3'd5, 0, 16'h0002, 0, 0);
      check_val("samedest_mask_held", bus.pending_mask[5], 1);
      idle(1);
      check_val("samedest_mask_clear", bus.pending_mask[5], 0);

      // Protocol errors
      step(0, 0, 0, 0, 0, 1, 16'h1111);
      check_val("proto_unexpected_resp", bus.proto_err, 1);
      step(1, 0, 3'd6, 1, 0, 0, 0);
      idle(2);
      check_val("proto_sticky", bus.proto_err, 1);

      // Reset mid-flight with two pending loads
      do_reset();
      step(1, 1, 3'd1, 1, 0, 0, 0);
      step(1, 1, 3'd2, 1, 0, 0, 0);
      do_reset();
      check_val("midreset_occupancy", bus.occupancy, 0);
      step(0, 0, 0, 0, 0, 1, 16'h2222);
      check_val("midreset_resp_err", bus.proto_err, 1);

      // Randomized traffic
      do_reset();
      for (int c = 0; c < 600; c++) begin
         bit rv;
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            rv = model_has_waiting_load() ? ($urandom_range(0, 2) == 0)
                                          : ($urandom_range(0, 79) == 0);
            step($urandom_range(0, 2) != 0, $urandom_range(0, 9) != 0,
                 REG_AW'($urandom), $urandom_range(0, 1) == 1, DATA_W'($urandom),
                 rv, DATA_W'($urandom));
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
